// File: rtl/tt_um_perceptron_mac.sv
// Serial perceptron: shift-loaded signed weights and bias,
// one saturating multiply-accumulate per cycle, fire bit and clipped sum.
module tt_um_perceptron_mac #(
  parameter int N_IN     = 8,
  parameter int W_BITS   = 4,
  parameter int ACC_BITS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int XW = ACC_BITS - W_BITS;

  localparam logic [IW-1:0] LAST = IW'(N_IN - 1);

  localparam logic [ACC_BITS-1:0] R_HI = ACC_BITS'(15);
  localparam logic [ACC_BITS-1:0] R_LO = ACC_BITS'(-16);

  localparam logic [ACC_BITS-1:0] A_MAX =
    {1'b0, {(ACC_BITS-1){1'b1}}};
  localparam logic [ACC_BITS-1:0] A_MIN =
    {1'b1, {(ACC_BITS-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [W_BITS-1:0] data;
  logic              wr_w;
  logic              wr_b;
  logic              start;

  assign data  = uio_in[W_BITS-1:0];
  assign wr_w  = uio_in[4];
  assign wr_b  = uio_in[5];
  assign start = uio_in[6];

  logic [W_BITS-1:0]   w [N_IN];
  logic [W_BITS-1:0]   bias;
  logic [N_IN-1:0]     x;
  logic [ACC_BITS-1:0] acc;
  logic [IW-1:0]       idx;

  logic       y;
  logic       valid;
  logic [4:0] result;
  logic       busy;

  logic ld_w;
  logic ld_b;
  logic go;
  logic step;
  logic fin;

  logic [W_BITS-1:0]   w_sel;
  logic                x_sel;
  logic [ACC_BITS-1:0] term;
  logic [ACC_BITS:0]   sum;
  logic [ACC_BITS-1:0] acc_nx;
  logic [ACC_BITS-1:0] bias_ext;
  logic [4:0]          res_nx;
  logic                pos;

  // state register, advances only on enabled edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else if (ena) begin
      state <= state_nx;
    end
  end

  // next state and per-cycle control strobes
  always_comb begin
    state_nx = state;
    ld_w     = 1'b0;
    ld_b     = 1'b0;
    go       = 1'b0;
    step     = 1'b0;
    fin      = 1'b0;
    unique case (state)
      S_IDLE: begin
        ld_w = wr_w;
        ld_b = wr_b;
        go   = start & ~wr_w & ~wr_b;
        if (go) begin
          state_nx = S_ACCUM;
        end
      end
      S_ACCUM: begin
        step = 1'b1;
        if (idx == LAST) begin
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        fin      = 1'b1;
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // saturating accumulate of the selected weight term
  always_comb begin
    w_sel    = w[idx];
    x_sel    = x[idx];
    term     = '0;
    bias_ext = {{XW{bias[W_BITS-1]}}, bias};
    if (x_sel) begin
      term = {{XW{w_sel[W_BITS-1]}}, w_sel};
    end
    sum = {acc[ACC_BITS-1], acc}
        + {term[ACC_BITS-1], term};
    acc_nx = sum[ACC_BITS-1:0];
    if (sum[ACC_BITS] != sum[ACC_BITS-1]) begin
      acc_nx = sum[ACC_BITS] ? A_MIN : A_MAX;
    end
  end

  // clip to signed 5 bits and decide firing
  always_comb begin
    res_nx = acc[4:0];
    pos    = ~acc[ACC_BITS-1] & (|acc);
    unique case (1'b1)
      ($signed(acc) > $signed(R_HI)): res_nx = 5'b01111;
      ($signed(acc) < $signed(R_LO)): res_nx = 5'b10000;
      default:                        res_nx = acc[4:0];
    endcase
  end

  // weight shift chain and bias, writable only while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_IN; i++) begin
        w[i] <= '0;
      end
      bias <= '0;
    end else if (ena) begin
      if (ld_w) begin
        for (int i = 0; i < N_IN - 1; i++) begin
          w[i] <= w[i+1];
        end
        w[N_IN-1] <= data;
      end
      if (ld_b) begin
        bias <= data;
      end
    end
  end

  // input latch, accumulator and term index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x   <= '0;
      acc <= '0;
      idx <= '0;
    end else if (ena) begin
      unique case (1'b1)
        go: begin
          x   <= ui_in[N_IN-1:0];
          acc <= bias_ext;
          idx <= '0;
        end
        step: begin
          acc <= acc_nx;
          idx <= (idx == LAST) ? '0 : idx + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // result registers and single-cycle valid pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y      <= 1'b0;
      valid  <= 1'b0;
      result <= '0;
    end else if (ena) begin
      valid <= fin;
      if (fin) begin
        y      <= pos;
        result <= res_nx;
      end
    end
  end

  assign busy    = (state != S_IDLE);
  assign uo_out  = {result, busy, valid, y};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  logic unused_ok;
  assign unused_ok = &{1'b0, ui_in, uio_in};

endmodule

// File: tb/tb_tt_um_perceptron_mac.sv
// Bench for tt_um_perceptron_mac: vector table, scoreboard queue,
// plus hand sequences for busy, ena gating and mid-run reset.
module tb_tt_um_perceptron_mac;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic [7:0] uo6;
  logic [7:0] uio_out6;
  logic [7:0] uio_oe6;

  always #5 clk = ~clk;

  tt_um_perceptron_mac dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  tt_um_perceptron_mac #(.ACC_BITS(6)) dut6 (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo6),
    .uio_out(uio_out6),
    .uio_oe (uio_oe6)
  );

  typedef struct packed {
    logic       y8;
    logic [4:0] r8;
    logic       y6;
    logic [4:0] r6;
  } exp_t;

  typedef struct packed {
    logic        reload;
    logic [31:0] wv;
    logic [3:0]  b;
    logic [7:0]  x;
    exp_t        e;
  } vec_t;

  localparam int NV = 11;

  vec_t vecs [NV];
  exp_t sbq [$];
  int   checks = 0;
  int   fails = 0;

  task automatic chk(input string name, input int act,
                     input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [31:0] wv,
                      input logic [3:0] b);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      uio_in = 8'h10 | {4'h0, wv[4*i +: 4]};
    end
    @(negedge clk);
    uio_in = 8'h20 | {4'h0, b};
    @(negedge clk);
    uio_in = 8'h00;
  endtask

  task automatic run(input logic [7:0] x, input exp_t e,
                     input int gate_at, input int gate_len,
                     input int inj_at, input int exp_lat,
                     input string tag);
    int   n;
    bit   busy_ok;
    bit   seen;
    exp_t g;
    @(negedge clk);
    ui_in  = x;
    uio_in = 8'h40;
    sbq.push_back(e);
    busy_ok = 1'b1;
    seen    = 1'b0;
    for (n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) begin
        uio_in = 8'h00;
        ui_in  = 8'($urandom);
      end
      if (inj_at > 0 && n == inj_at) uio_in = 8'h75;
      if (inj_at > 0 && n == inj_at + 1) uio_in = 8'h00;
      ena = !(gate_len > 0 && n > gate_at &&
              n <= gate_at + gate_len);
      @(posedge clk);
      #1;
      if (uo_out[1]) begin
        seen = 1'b1;
        break;
      end
      if (!uo_out[2]) busy_ok = 1'b0;
    end
    ena = 1'b1;
    chk({tag, " latency"}, n, exp_lat);
    chk({tag, " busy"}, int'(busy_ok), 1);
    if (seen) begin
      chk({tag, " busy_low"}, int'(uo_out[2]), 0);
      chk({tag, " valid6"}, int'(uo6[1]), 1);
      if (sbq.size() == 0) begin
        chk({tag, " sb_empty"}, 1, 0);
      end else begin
        g = sbq.pop_front();
        chk({tag, " y"}, int'(uo_out[0]), int'(g.y8));
        chk({tag, " result"}, int'(uo_out[7:3]), int'(g.r8));
        chk({tag, " y6"}, int'(uo6[0]), int'(g.y6));
        chk({tag, " result6"}, int'(uo6[7:3]), int'(g.r6));
      end
    end else begin
      void'(sbq.pop_front());
    end
  endtask

  task automatic quiet(input int cycles, input string tag);
    bit extra;
    extra = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (uo_out[1] || uo6[1]) extra = 1'b1;
    end
    chk({tag, " no_valid"}, int'(extra), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t and1;
    exp_t zero;
    logic [7:0] hold;
    and1 = '{1'b1, 5'h01, 1'b1, 5'h01};
    zero = '{1'b0, 5'h00, 1'b0, 5'h00};

    vecs[0]  = '{1'b1, 32'h00000011, 4'hF, 8'h03, and1};
    vecs[1]  = '{1'b0, 32'h00000011, 4'hF, 8'h01, zero};
    vecs[2]  = '{1'b0, 32'h00000011, 4'hF, 8'h00,
                 '{1'b0, 5'h1F, 1'b0, 5'h1F}};
    vecs[3]  = '{1'b1, 32'h88888888, 4'h8, 8'hFF,
                 '{1'b0, 5'h10, 1'b0, 5'h10}};
    vecs[4]  = '{1'b1, 32'h77777777, 4'h7, 8'hFF,
                 '{1'b1, 5'h0F, 1'b1, 5'h0F}};
    vecs[5]  = '{1'b1, 32'h2D50F387, 4'h2, 8'hA5,
                 '{1'b1, 5'h0F, 1'b1, 5'h0F}};
    vecs[6]  = '{1'b0, 32'h2D50F387, 4'h2, 8'h5A,
                 '{1'b0, 5'h16, 1'b0, 5'h16}};
    vecs[7]  = '{1'b1, 32'h88887777, 4'h7, 8'hFF,
                 '{1'b1, 5'h03, 1'b0, 5'h1F}};
    vecs[8]  = '{1'b0, 32'h88887777, 4'h7, 8'h0F,
                 '{1'b1, 5'h0F, 1'b1, 5'h0F}};
    vecs[9]  = '{1'b0, 32'h88887777, 4'h7, 8'hF0,
                 '{1'b0, 5'h10, 1'b0, 5'h10}};
    vecs[10] = '{1'b1, 32'h00000011, 4'hF, 8'h02, zero};

    // reset with random inputs
    ui_in  = 8'($urandom);
    uio_in = 8'($urandom);
    repeat (3) @(posedge clk);
    #1;
    chk("rst uo_out", int'(uo_out), 0);
    chk("rst uio_out", int'(uio_out), 0);
    chk("rst uio_oe", int'(uio_oe), 0);
    chk("rst uo6", int'(uo6), 0);
    @(negedge clk);
    uio_in = 8'h00;
    rst_n  = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst busy", int'(uo_out[2]), 0);
    chk("post_rst uo_out", int'(uo_out), 0);

    // table; reload=0 rows start back-to-back on the valid cycle
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].reload) load(vecs[i].wv, vecs[i].b);
      run(vecs[i].x, vecs[i].e, 0, 0, 0, 9,
          $sformatf("vec%0d", i));
    end

    // strobes during accumulation are ignored
    load(32'h00000011, 4'hF);
    run(8'h03, and1, 0, 0, 3, 9, "busy_inj");
    quiet(12, "busy_inj");
    run(8'h03, and1, 0, 0, 0, 9, "busy_rerun");

    // ena low mid-accumulate stretches latency
    run(8'h03, and1, 4, 3, 0, 12, "gated");

    // valid holds while ena is low
    hold = uo_out;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ena = 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("hold%0d uo_out", i), int'(uo_out),
          int'(hold));
    end
    @(negedge clk);
    ena = 1'b1;
    @(posedge clk);
    #1;
    chk("hold release valid", int'(uo_out[1]), 0);
    chk("hold release result", int'(uo_out[7:3]), 1);

    // reset while accumulating at idx=4
    @(negedge clk);
    ui_in  = 8'h03;
    uio_in = 8'h40;
    @(posedge clk);
    #1;
    uio_in = 8'h00;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst busy_before", int'(uo_out[2]), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst uo_out", int'(uo_out), 0);
    chk("midrst uo6", int'(uo6), 0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet(15, "midrst");
    run(8'h03, zero, 0, 0, 0, 9, "midrst_rerun");

    chk("sb drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/tt_um_perceptron_mac.md
Name: tt_um_perceptron_mac

Overview:
Programmable single perceptron with N_IN binary inputs and signed per-input weights, evaluated serially by one multiply-accumulate step per cycle.
- Weights and bias are loaded through a shift interface on uio_in.
- A start strobe latches the input vector and accumulates bias + Σ x[i]·w[i] over N_IN cycles, with saturating arithmetic.
- Outputs are the fire bit (sum > 0) and a clipped sum.
- Sits at the chip top in the Tiny Tapeout harness and is the parametrised successor of the fixed 2-input AND neuron.

Parameters:
N_IN, 8, number of binary inputs (1..8), taken from ui_in[N_IN-1:0]
W_BITS, 4, signed weight and bias width (two's complement), taken from uio_in[W_BITS-1:0]; 1..4
ACC_BITS, 8, signed accumulator width; must be ≥ 5

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  asynchronous active-low reset
ena  input  1  clock enable; when low, all state holds and all strobes are ignored
ui_in  input  8  input vector x; bits above N_IN-1 ignored
uio_in  input  8  [3:0] weight/bias data, [4] wr_w, [5] wr_b, [6] start, [7] unused
uo_out  output  8  [0] y, [1] valid, [2] busy, [7:3] result clipped to signed 5 bits
uio_out  output  8  tied 0
uio_oe  output  8  tied 0 (all bidirectionals are inputs)

Behaviour:
- Reset (async assert, sync-released by the harness):
  - state=IDLE; all weights w[0..N_IN-1]=0; bias=0; acc=0; idx=0; latched x=0.
  - y=0, valid=0, busy=0, result=0, so uo_out=0x00.
- All sequential updates below occur only on rising edges with ena=1. With ena=0, nothing changes and valid holds its current value.
- Weight load (IDLE only):
  - wr_w=1 shifts the weight chain: w[N_IN-1]<=data, w[i]<=w[i+1].
  - After N_IN writes, the first-written value sits in w[0].
- Bias load (IDLE only): wr_b=1 sets bias<=data.
- wr_w and wr_b in the same cycle: both are performed.
- Strobes are level-sampled each enabled edge; there is no edge detection.
- Priority in IDLE: if wr_w or wr_b is high, start is ignored that cycle.
- wr_w, wr_b and start while busy: all ignored; weights and bias are stable during a computation.
- FSM transitions:
  - IDLE: on start at edge k, latch x<=ui_in[N_IN-1:0], acc<=sign-extended bias, idx<=0, go to ACCUM.
  - ACCUM: each edge adds (x[idx] ? sign-extended w[idx] : 0) to acc, then idx<=idx+1. The edge that processes idx=N_IN-1 moves to DONE, so the last term is added at edge k+N_IN.
  - DONE: at edge k+N_IN+1:
    - y<=(acc > 0) as a signed comparison.
    - result<=acc clamped to [-16,15].
    - valid<=1 for exactly one cycle.
    - go to IDLE.
- Latency: the valid pulse is visible in the cycle after edge k+N_IN+1.
- busy = (state != IDLE), registered-state decode, high for N_IN+1 cycles. valid rises as busy falls.
- Saturation is applied on every add: the sum is clamped to [-2^(ACC_BITS-1), 2^(ACC_BITS-1)-1]. No wrap-around is permitted.
- y and result hold their values until the next DONE or reset.
- valid is cleared on the next enabled edge after it is set.
- Reset mid-operation: immediate return to the reset state. Weights are lost and no valid pulse is produced.
- Back-to-back operation: start is accepted on the first IDLE edge after DONE, i.e. the same cycle valid is high.

Test Plan:
- Reset: assert rst_n=0 with random inputs -> uo_out=0x00, uio_out=0x00, uio_oe=0x00; after release busy=0.
- AND configuration:
  - Stimulus: shift weights 1,1,0,0,0,0,0,0 via wr_w (data 0x1,0x1,0x0…), then wr_b with data 0xF (-1).
  - Start with ui_in=0x03 -> valid exactly 9 edges after start, y=1, uo_out[7:3]=00001.
  - Start with ui_in=0x01 -> y=0, result=0.
  - Start with ui_in=0x00 -> y=0, result=11111 (-1).
- Extremes:
  - All weights 0x8 (-8), bias 0x8, ui_in=0xFF -> acc=-72, result=10000 (-16), y=0.
  - With ACC_BITS=6, all weights 0x7, bias 0x7, ui_in=0xFF -> acc saturates to 31, result=01111, y=1.
- Busy protection: during ACCUM, pulse start, wr_w=1 data 0x5, and wr_b -> single valid pulse only; an identical rerun gives an identical result, confirming weights are unchanged.
- ena gating: drop ena for 3 cycles mid-ACCUM -> valid delayed by exactly 3 cycles, result identical to the ungated run; valid does not clear while ena=0.
- Reset mid-run: assert rst_n at ACCUM idx=4 -> outputs 0 immediately, no valid pulse; a rerun after reset without reloading gives result=0, y=0.
